pll_lock_supervisor: RTL and testbench

Consumes the `locked` output of a core PLL and drives that PLL's `rst` input, closing the loop around the clock generator. It debounces and qualifies lock, then releases the core's reset only after lock has been continuously stable. On lock timeout it re-resets the PLL with bounded retries. It latches a fault when retries are exhausted. It runs on the PLL reference clock and sits between the PLL instance and the core reset tree.

---
 rtl/pll_sup_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/pll_lock_supervisor.sv | 140 ++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor.
// State encoding and loss-counter width live here so the bench and RTL agree.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RESET = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } sup_state_e;

    localparam int LOSS_COUNT_W = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer, async active-high reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= d;
            r_q    <= r_meta;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Qualifies PLL lock, sequences PLL/core resets with bounded retries and a latched fault.
// Optional PLL_LOCK_SUPERVISOR_LOSS_COUNT_EN adds a saturating RUN lock-loss counter.
//
// state        | meaning
// PLL_RESET    | pll_rst held high for PLL_RST_CYCLES
// WAIT_LOCK    | waiting for synchronized lock, bounded by LOCK_TIMEOUT_CYCLES
// STABILIZE    | lock must hold LOCK_STABLE_CYCLES consecutive cycles
// RUN          | core released, lock_ready high
// FAULT        | retries exhausted, waits for clear_fault
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3,
    localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1)
) (
    input  logic                    refclk,
    input  logic                    rst,
    input  logic                    pll_locked,
    input  logic                    clear_fault,
    output logic                    pll_rst,
    output logic                    core_rst,
    output logic                    lock_ready,
    output logic                    fault,
    output logic [RW-1:0]           retry_count,
    output logic [LOSS_COUNT_W-1:0] loss_count
);

    localparam int CW = $clog2(max3(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES));

    sup_state_e      r_state;
    sup_state_e      w_next;
    logic [CW-1:0]   r_cnt;
    logic [RW-1:0]   r_retry;
    logic [RW-1:0]   w_retry_next;
    logic            w_locked_s;
    logic            r_pll_rst;
    logic            r_core_rst;
    logic            r_lock_ready;
    logic            r_fault;

    sync_2ff u_sync_locked (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (w_locked_s)
    );

    // Lock takes priority over timeout in WAIT_LOCK.
    always_comb begin
        w_next       = r_state;
        w_retry_next = r_retry;
        case (r_state)
            ST_PLL_RESET: begin
                if (r_cnt == CW'(PLL_RST_CYCLES - 1)) w_next = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (w_locked_s) begin
                    w_next = ST_STABILIZE;
                end else if (r_cnt == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
                    if (r_retry == RW'(MAX_RETRIES)) begin
                        w_next = ST_FAULT;
                    end else begin
                        w_retry_next = r_retry + RW'(1);
                        w_next       = ST_PLL_RESET;
                    end
                end
            end
            ST_STABILIZE: begin
                if (!w_locked_s) w_next = ST_WAIT_LOCK;
                else if (r_cnt == CW'(LOCK_STABLE_CYCLES - 1)) w_next = ST_RUN;
            end
            ST_RUN: begin
                if (!w_locked_s) begin
                    w_next       = ST_PLL_RESET;
                    w_retry_next = '0;
                end
            end
            ST_FAULT: begin
                if (clear_fault) begin
                    w_next       = ST_PLL_RESET;
                    w_retry_next = '0;
                end
            end
            default: begin
                w_next       = ST_PLL_RESET;
                w_retry_next = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_PLL_RESET;
            r_cnt        <= '0;
            r_retry      <= '0;
            r_pll_rst    <= 1'b1;
            r_core_rst   <= 1'b1;
            r_lock_ready <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_cnt        <= (w_next != r_state) ? '0 : r_cnt + CW'(1);
            r_retry      <= w_retry_next;
            r_pll_rst    <= (w_next == ST_PLL_RESET) || (w_next == ST_FAULT);
            r_core_rst   <= (w_next != ST_RUN);
            r_lock_ready <= (w_next == ST_RUN);
            r_fault      <= (w_next == ST_FAULT);
        end
    end

    assign pll_rst     = r_pll_rst;
    assign core_rst    = r_core_rst;
    assign lock_ready  = r_lock_ready;
    assign fault       = r_fault;
    assign retry_count = r_retry;

`ifdef PLL_LOCK_SUPERVISOR_LOSS_COUNT_EN
    logic [LOSS_COUNT_W-1:0] r_loss;
    logic                    w_loss_event;

    assign w_loss_event = (r_state == ST_RUN) && (w_next == ST_PLL_RESET);

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_loss <= '0;
        end else if (w_loss_event && (r_loss != '1)) begin
            r_loss <= r_loss + LOSS_COUNT_W'(1);
        end
    end

    assign loss_count = r_loss;
`else
    assign loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: vector table plus fault/reset sequences.
module tb_pll_lock_supervisor;

    localparam int RST_C  = 4;
    localparam int TO_C   = 32;
    localparam int STB_C  = 8;
    localparam int MAXR   = 2;
    localparam int RWB    = 2;
`ifdef PLL_LOCK_SUPERVISOR_LOSS_COUNT_EN
    localparam logic [7:0] EXP_LOSS = 8'd1;
`else
    localparam logic [7:0] EXP_LOSS = 8'd0;
`endif

    logic           refclk = 1'b0;
    logic           rst;
    logic           pll_locked;
    logic           clear_fault;
    logic           pll_rst;
    logic           core_rst;
    logic           lock_ready;
    logic           fault;
    logic [RWB-1:0] retry_count;
    logic [7:0]     loss_count;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        string      name;
        int         n;
        logic       locked;
        logic       clr;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[$];

    pll_lock_supervisor #(
        .PLL_RST_CYCLES      (RST_C),
        .LOCK_TIMEOUT_CYCLES (TO_C),
        .LOCK_STABLE_CYCLES  (STB_C),
        .MAX_RETRIES         (MAXR)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .clear_fault (clear_fault),
        .pll_rst     (pll_rst),
        .core_rst    (core_rst),
        .lock_ready  (lock_ready),
        .fault       (fault),
        .retry_count (retry_count),
        .loss_count  (loss_count)
    );

    always #5 refclk = ~refclk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge refclk);
            #1;
        end
    endtask

    function automatic logic [5:0] outs();
        return {pll_rst, core_rst, lock_ready, fault, retry_count};
    endfunction

    task automatic chk(input string nm, input logic [5:0] exp);
        logic [5:0] act;
        act = outs();
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: {pll_rst,core_rst,lock_ready,fault,retry} got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_loss(input string nm, input logic [7:0] exp);
        n_chk++;
        if (loss_count !== exp) begin
            n_err++;
            $display("FAIL %s: loss_count got %0d expected %0d", nm, loss_count, exp);
        end
    endtask

    task automatic add(input string nm, input int n, input logic lk, input logic clr,
                       input logic ep, input logic ec, input logic er, input logic ef,
                       input logic [1:0] eret);
        vec_t v;
        v.name = nm; v.n = n; v.locked = lk; v.clr = clr;
        v.exp  = {ep, ec, er, ef, eret};
        vecs.push_back(v);
    endtask

    initial begin
        int         waited;
        logic [5:0] e;

        // Timeline after rst release; edge counts relative to the previous row.
        add("bringup_prst_hi",   3, 0, 0, 1, 1, 0, 0, 2'd0);
        add("bringup_prst_lo",   1, 0, 0, 0, 1, 0, 0, 2'd0);
        add("bringup_wait",      6, 0, 0, 0, 1, 0, 0, 2'd0);
        add("bringup_qualify",  10, 1, 0, 0, 1, 0, 0, 2'd0);
        add("bringup_run",       1, 1, 0, 0, 0, 1, 0, 2'd0);
        add("loss_edge_m",       1, 0, 0, 0, 0, 1, 0, 2'd0);
        add("loss_edge_m1",      1, 0, 0, 0, 0, 1, 0, 2'd0);
        add("loss_edge_m2",      1, 0, 0, 1, 1, 0, 0, 2'd0);
        add("loss_prst_hold",    3, 0, 0, 1, 1, 0, 0, 2'd0);
        add("loss_prst_end",     1, 0, 0, 0, 1, 0, 0, 2'd0);
        add("glitch_stabilize",  5, 1, 0, 0, 1, 0, 0, 2'd0);
        add("glitch_drop",       3, 0, 0, 0, 1, 0, 0, 2'd0);
        add("glitch_requalify", 10, 1, 0, 0, 1, 0, 0, 2'd0);
        add("glitch_run",        1, 1, 0, 0, 0, 1, 0, 2'd0);
        add("clr_in_run",        1, 1, 1, 0, 0, 1, 0, 2'd0);
        add("clr_in_run_after",  3, 1, 0, 0, 0, 1, 0, 2'd0);

        rst = 1'b1; pll_locked = 1'b0; clear_fault = 1'b0;
        #12;
        chk("reset_state", 6'b110000);
        chk_loss("reset_loss", 8'd0);
        @(posedge refclk); #1;
        rst = 1'b0;

        foreach (vecs[i]) begin
            pll_locked  = vecs[i].locked;
            clear_fault = vecs[i].clr;
            tick(vecs[i].n);
            chk(vecs[i].name, vecs[i].exp);
            if (vecs[i].name == "loss_prst_end") chk_loss("loss_after_run_drop", EXP_LOSS);
        end
        clear_fault = 1'b0;

        // Async reset in STABILIZE: drop lock, ride the re-reset, then re-lock.
        pll_locked = 1'b0;
        tick(1);
        waited = 0;
        while (pll_rst !== 1'b1 && waited < 20) begin tick(1); waited++; end
        while (pll_rst !== 1'b0 && waited < 50) begin tick(1); waited++; end
        n_chk++;
        if (waited >= 50) begin
            n_err++;
            $display("FAIL wait_reacquire: pll_rst got %b expected 0 within 50 cycles", pll_rst);
        end
        pll_locked = 1'b1;
        tick(4);
        chk("arst_pre_stabilize", 6'b010000);
        #3 rst = 1'b1;
        #1;
        chk("arst_immediate", 6'b110000);
        chk_loss("arst_loss_cleared", 8'd0);
        pll_locked = 1'b0;
        @(posedge refclk); #1;
        rst = 1'b0;

        // Never lock: initial pulse, two retries, then FAULT.
        for (int k = 1; k <= 108; k++) begin
            tick(1);
            e[5]   = (k < 4) || (k >= 36 && k < 40) || (k >= 72 && k < 76) || (k >= 108);
            e[4]   = 1'b1;
            e[3]   = 1'b0;
            e[2]   = (k >= 108);
            e[1:0] = (k >= 72) ? 2'd2 : (k >= 36) ? 2'd1 : 2'd0;
            chk($sformatf("timeout_k%0d", k), e);
        end
        for (int k = 0; k < 100; k++) begin
            tick(1);
            chk($sformatf("fault_hold_%0d", k), 6'b110110);
        end

        // Fault recovery, lock arriving 5 cycles after the clear.
        clear_fault = 1'b1;
        tick(1);
        clear_fault = 1'b0;
        chk("clear_to_pll_reset", 6'b110000);
        tick(4);
        chk("clear_wait_lock", 6'b010000);
        pll_locked = 1'b1;
        tick(10);
        chk("recover_qualify", 6'b010000);
        tick(1);
        chk("recover_run", 6'b001000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
